// File: rtl/ice_arb_pkg.sv
// Shared definitions for the ice_bus arbiters: state encoding, abort id width
// and the default watchdog length.
package ice_arb_pkg;

  localparam int unsigned ABORT_ID_W      = 3;
  localparam int unsigned DEFAULT_TIMEOUT = 65535;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_OWN  = 1'b1;

  // Index width for an N-entry vector; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-side byte streams plus the UART transmit handshake and arbiter status.
// master: sources/UART side, slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
  logic [NUM_REQ-1:0]              req_last;
  logic [NUM_REQ-1:0]              req_ready;
  logic [DATA_WIDTH-1:0]           tx_data;
  logic                            tx_valid;
  logic                            tx_ready;
  logic [NUM_REQ-1:0]              grant;
  logic                            busy;
  logic                            abort_err;
  logic [ice_arb_pkg::ABORT_ID_W-1:0] abort_id;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy, abort_err, abort_id
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy, abort_err, abort_id
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or above i_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int unsigned w_pos;

  // Walk the requests in priority order starting at the pointer.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_onehot[w_pos] = 1'b1;
        o_idx           = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit path between NUM_REQ message
// sources. A grant is held for a whole message; a watchdog drops the grant
// when the owner stops offering bytes for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter
  import ice_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned TO_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned       IDX_W   = idx_width(NUM_REQ);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 1);

  logic [0:0]            r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic [IDX_W-1:0]      r_owner;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [TO_W-1:0]       r_count;
  logic                  r_busy;
  logic                  r_abort_err;
  logic [ABORT_ID_W-1:0] r_abort_id;

  logic [NUM_REQ-1:0]    w_pick_onehot;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_any;
  logic                  w_own;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_xfer;
  logic                  w_stall;
  logic                  w_timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req    (bus.req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Pass-through of the owner's stream, driven only from registered grant.
  always_comb begin
    w_own         = (r_state == ARB_OWN);
    w_owner_valid = bus.req_valid[r_owner];
    w_owner_last  = bus.req_last[r_owner];
    w_xfer        = w_own && w_owner_valid && bus.tx_ready;
    // Backpressure never counts as starvation; only owner-valid-low with a ready sink does.
    w_stall       = w_own && !w_owner_valid && bus.tx_ready;
    w_timeout     = (TIMEOUT_CYCLES != 0) && w_stall && (r_count == TO_LAST);

    bus.tx_valid  = w_own && w_owner_valid;
    bus.tx_data   = w_own ? bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    bus.req_ready = w_own ? (r_grant & {NUM_REQ{bus.tx_ready}}) : '0;
    bus.grant     = r_grant;
    bus.busy      = r_busy;
    bus.abort_err = r_abort_err;
    bus.abort_id  = r_abort_id;
  end

  // Grant FSM, round-robin pointer, watchdog and abort reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_abort_err <= 1'b0;
      r_abort_id  <= '0;
    end else begin
      r_abort_err <= 1'b0;
      if (r_state == ARB_IDLE) begin
        r_count <= '0;
        if (w_pick_any) begin
          r_state  <= ARB_OWN;
          r_grant  <= w_pick_onehot;
          r_owner  <= w_pick_idx;
          r_rr_ptr <= (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
          r_busy   <= 1'b1;
        end
      end else begin
        if (w_xfer) begin
          r_count <= '0;
          if (w_owner_last) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end else if (w_timeout) begin
          r_state     <= ARB_IDLE;
          r_grant     <= '0;
          r_busy      <= 1'b0;
          r_count     <= '0;
          r_abort_err <= 1'b1;
          r_abort_id  <= ABORT_ID_W'(r_owner);
        end else if (w_stall) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

endmodule
